// File: rtl/vga_rx_monitor.sv
// Receive-side VGA timing monitor: recovers pixel coordinates from the sampled
// sync/blank stream, measures line and frame geometry, and declares lock.
module vga_rx_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       vga_clk,
  input  logic       hs,
  input  logic       vs,
  input  logic       blank,
  output logic [9:0] rx_x,
  output logic [9:0] rx_y,
  output logic       rx_de,
  output logic       frame_pulse,
  output logic       locked,
  output logic [7:0] err_count,
  output logic [9:0] last_h_period,
  output logic [9:0] last_v_lines
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam logic [9:0] CNT_MAX    = 10'h3FF;
  localparam logic [9:0] H_TOTAL_C  = 10'(H_TOTAL);
  localparam logic [9:0] H_ACTIVE_C = 10'(H_ACTIVE);
  localparam logic [9:0] V_TOTAL_C  = 10'(V_TOTAL);
  localparam logic [9:0] V_ACTIVE_C = 10'(V_ACTIVE);
  localparam logic [7:0] LOCK_C     = 8'(LOCK_FRAMES);

  function automatic logic [9:0] inc10(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

  function automatic logic [7:0] inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic       vclk_q, vclk_prev_q, hs_q, vs_q, blank_q;
  logic       hs_t_q, vs_t_q, blank_t_q, hs_t_d, vs_t_d, blank_t_d;
  logic [9:0] hcnt_q, hcnt_d, acnt_q, acnt_d, vcnt_q, vcnt_d, yact_q, yact_d;
  logic       mis_q, mis_d;
  logic [7:0] good_q, good_d;
  state_t     state_q, state_d;
  logic [9:0] rx_x_q, rx_x_d, rx_y_q, rx_y_d;
  logic       rx_de_q, rx_de_d, frame_pulse_q, frame_pulse_d, locked_q, locked_d;
  logic [7:0] err_count_q, err_count_d;
  logic [9:0] last_h_period_q, last_h_period_d, last_v_lines_q, last_v_lines_d;

  logic       tick, hs_fall, vs_fall, blank_rise, blank_fall, frame_good;
  logic [9:0] h_period;

  // Edges are judged between the samples of consecutive pixel ticks.
  assign tick       = vclk_q & ~vclk_prev_q;
  assign hs_fall    = tick & hs_t_q & ~hs_q;
  assign vs_fall    = tick & vs_t_q & ~vs_q;
  assign blank_rise = tick & ~blank_t_q & blank_q;
  assign blank_fall = tick & blank_t_q & ~blank_q;
  assign h_period   = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 10'd1;

  always_comb begin
    hs_t_d          = hs_t_q;
    vs_t_d          = vs_t_q;
    blank_t_d       = blank_t_q;
    hcnt_d          = hcnt_q;
    acnt_d          = acnt_q;
    vcnt_d          = vcnt_q;
    yact_d          = yact_q;
    mis_d           = mis_q;
    good_d          = good_q;
    state_d         = state_q;
    err_count_d     = err_count_q;
    rx_x_d          = rx_x_q;
    rx_y_d          = rx_y_q;
    rx_de_d         = 1'b0;
    frame_pulse_d   = 1'b0;
    last_h_period_d = last_h_period_q;
    last_v_lines_d  = last_v_lines_q;
    frame_good      = 1'b0;

    if (tick) begin
      hs_t_d    = hs_q;
      vs_t_d    = vs_q;
      blank_t_d = blank_q;
      hcnt_d    = inc10(hcnt_q);
    end

    if (hs_fall) begin
      last_h_period_d = h_period;
      hcnt_d          = '0;
      vcnt_d          = inc10(vcnt_q);
      if (h_period != H_TOTAL_C) mis_d = 1'b1;
    end

    if (tick && blank_q) begin
      rx_de_d = 1'b1;
      rx_x_d  = blank_rise ? 10'd0 : acnt_q;
      rx_y_d  = yact_q;
      acnt_d  = blank_rise ? 10'd1 : inc10(acnt_q);
    end

    if (blank_fall) begin
      if (acnt_q != H_ACTIVE_C) mis_d = 1'b1;
      yact_d = inc10(yact_q);
    end

    // Frame close sees this tick's hs/blank updates, so a coincident hs edge
    // belongs to the frame being closed.
    if (vs_fall) begin
      frame_good     = !mis_d && (vcnt_d == V_TOTAL_C) && (yact_d == V_ACTIVE_C);
      last_v_lines_d = vcnt_d;
      vcnt_d         = '0;
      yact_d         = '0;
      mis_d          = 1'b0;
      case (state_q)
        SEARCH: state_d = MEASURE;
        MEASURE: begin
          frame_pulse_d = 1'b1;
          if (frame_good) begin
            good_d = good_q + 8'd1;
            if (good_d == LOCK_C) state_d = LOCKED;
          end else begin
            good_d      = '0;
            err_count_d = inc8(err_count_q);
          end
        end
        LOCKED: begin
          frame_pulse_d = 1'b1;
          if (!frame_good) begin
            state_d     = MEASURE;
            good_d      = '0;
            err_count_d = inc8(err_count_q);
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vclk_q          <= 1'b0;
      vclk_prev_q     <= 1'b0;
      hs_q            <= 1'b0;
      vs_q            <= 1'b0;
      blank_q         <= 1'b0;
      hs_t_q          <= 1'b0;
      vs_t_q          <= 1'b0;
      blank_t_q       <= 1'b0;
      hcnt_q          <= '0;
      acnt_q          <= '0;
      vcnt_q          <= '0;
      yact_q          <= '0;
      mis_q           <= 1'b0;
      good_q          <= '0;
      state_q         <= SEARCH;
      err_count_q     <= '0;
      rx_x_q          <= '0;
      rx_y_q          <= '0;
      rx_de_q         <= 1'b0;
      frame_pulse_q   <= 1'b0;
      locked_q        <= 1'b0;
      last_h_period_q <= '0;
      last_v_lines_q  <= '0;
    end else begin
      vclk_q          <= vga_clk;
      vclk_prev_q     <= vclk_q;
      hs_q            <= hs;
      vs_q            <= vs;
      blank_q         <= blank;
      hs_t_q          <= hs_t_d;
      vs_t_q          <= vs_t_d;
      blank_t_q       <= blank_t_d;
      hcnt_q          <= hcnt_d;
      acnt_q          <= acnt_d;
      vcnt_q          <= vcnt_d;
      yact_q          <= yact_d;
      mis_q           <= mis_d;
      good_q          <= good_d;
      state_q         <= state_d;
      err_count_q     <= err_count_d;
      rx_x_q          <= rx_x_d;
      rx_y_q          <= rx_y_d;
      rx_de_q         <= rx_de_d;
      frame_pulse_q   <= frame_pulse_d;
      locked_q        <= locked_d;
      last_h_period_q <= last_h_period_d;
      last_v_lines_q  <= last_v_lines_d;
    end
  end

  assign rx_x          = rx_x_q;
  assign rx_y          = rx_y_q;
  assign rx_de         = rx_de_q;
  assign frame_pulse   = frame_pulse_q;
  assign locked        = locked_q;
  assign err_count     = err_count_q;
  assign last_h_period = last_h_period_q;
  assign last_v_lines  = last_v_lines_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor using a scaled-down raster
// (10 ticks/line, 6 active pixels, 6 lines/frame, 4 active lines).
module tb_vga_rx_monitor;

  localparam int HT = 10;
  localparam int HA = 6;
  localparam int VT = 6;
  localparam int VA = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       vga_clk_in = 1'b0;
  logic       hs_in = 1'b1;
  logic       vs_in = 1'b1;
  logic       blank_in = 1'b0;
  logic [9:0] rx_x, rx_y, last_h_period, last_v_lines;
  logic       rx_de, frame_pulse, locked;
  logic [7:0] err_count;

  int total = 0;
  int bad = 0;

  int pulse_cnt = 0;
  int de_cnt = 0;
  int snap_de = 0;
  int snap_locked = 0, snap_err = 0, snap_h = 0, snap_v = 0;
  int fx = 0, fy = 0, lx = 0, ly = 0;
  int snap_fx = 0, snap_fy = 0, snap_lx = 0, snap_ly = 0;

  vga_rx_monitor #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .V_TOTAL(VT), .V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut (
    .Clk(Clk), .Reset(Reset), .vga_clk(vga_clk_in), .hs(hs_in), .vs(vs_in),
    .blank(blank_in), .rx_x(rx_x), .rx_y(rx_y), .rx_de(rx_de),
    .frame_pulse(frame_pulse), .locked(locked), .err_count(err_count),
    .last_h_period(last_h_period), .last_v_lines(last_v_lines)
  );

  always #5 Clk = ~Clk;

  // Observer: counts pixels and snapshots the status outputs at each frame pulse.
  always @(negedge Clk) begin
    if (rx_de === 1'b1) begin
      if (de_cnt == 0) begin
        fx = int'(rx_x);
        fy = int'(rx_y);
      end
      lx = int'(rx_x);
      ly = int'(rx_y);
      de_cnt++;
    end
    if (frame_pulse === 1'b1) begin
      pulse_cnt++;
      snap_locked = int'(locked);
      snap_err    = int'(err_count);
      snap_h      = int'(last_h_period);
      snap_v      = int'(last_v_lines);
      snap_de     = de_cnt;
      snap_fx     = fx;
      snap_fy     = fy;
      snap_lx     = lx;
      snap_ly     = ly;
      de_cnt      = 0;
    end
  end

  // One pixel tick: vga_clk high for one Clk cycle, low for the next.
  task automatic send_tick(input logic h, input logic v, input logic b);
    @(negedge Clk);
    hs_in      = h;
    vs_in      = v;
    blank_in   = b;
    vga_clk_in = 1'b1;
    @(negedge Clk);
    vga_clk_in = 1'b0;
  endtask

  // Lines first_line..n_lines-1; vs low on line 4 (from hc 0, or from the hs
  // falling tick when vs_at_hs is set); odd_line gets length odd_len.
  task automatic send_frame(input int first_line, input int n_lines,
                            input int odd_line, input int odd_len, input bit vs_at_hs);
    logic h, v, b;
    int   len;
    for (int vc = first_line; vc < n_lines; vc++) begin
      len = (vc == odd_line) ? odd_len : HT;
      for (int hc = 0; hc < len; hc++) begin
        h = !((hc == len - 3) || (hc == len - 2));
        b = (hc < HA) && (vc < VA);
        v = vs_at_hs ? !((vc == 4) && (hc >= len - 3)) : !(vc == 4);
        send_tick(h, v, b);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset      = 1'b1;
    vga_clk_in = 1'b0;
    hs_in      = 1'b1;
    vs_in      = 1'b1;
    blank_in   = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    Reset = 1'b1;
    @(negedge Clk);
    total++; if (rx_x !== 10'd0) begin bad++; $display("[TB] FAIL reset_rx_x: got %0d want 0", rx_x); end
    total++; if (rx_y !== 10'd0) begin bad++; $display("[TB] FAIL reset_rx_y: got %0d want 0", rx_y); end
    total++; if (rx_de !== 1'b0) begin bad++; $display("[TB] FAIL reset_rx_de: got %0b want 0", rx_de); end
    total++; if (frame_pulse !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_pulse: got %0b want 0", frame_pulse); end
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL reset_locked: got %0b want 0", locked); end
    total++; if (err_count !== 8'd0) begin bad++; $display("[TB] FAIL reset_err: got %0d want 0", err_count); end
    total++; if (last_h_period !== 10'd0) begin bad++; $display("[TB] FAIL reset_last_h: got %0d want 0", last_h_period); end
    total++; if (last_v_lines !== 10'd0) begin bad++; $display("[TB] FAIL reset_last_v: got %0d want 0", last_v_lines); end
    Reset = 1'b0;
  endtask

  task automatic test_ideal_lock();
    int p0, p1;
    do_reset();
    p0 = pulse_cnt;
    send_frame(0, VT, -1, 0, 1'b0);
    total++; if (pulse_cnt - p0 != 0) begin bad++; $display("[TB] FAIL search_no_pulse: got %0d pulses want 0", pulse_cnt - p0); end
    send_frame(0, VT, -1, 0, 1'b0);
    total++; if (pulse_cnt - p0 != 1) begin bad++; $display("[TB] FAIL ideal_pulse1: got %0d pulses want 1", pulse_cnt - p0); end
    total++; if (snap_locked != 0) begin bad++; $display("[TB] FAIL ideal_locked_at_p1: got %0d want 0", snap_locked); end
    send_frame(0, VT, -1, 0, 1'b0);
    total++; if (pulse_cnt - p0 != 2) begin bad++; $display("[TB] FAIL ideal_pulse2: got %0d pulses want 2", pulse_cnt - p0); end
    total++; if (snap_locked != 1) begin bad++; $display("[TB] FAIL ideal_locked_at_p2: got %0d want 1", snap_locked); end
    total++; if (snap_err != 0) begin bad++; $display("[TB] FAIL ideal_err: got %0d want 0", snap_err); end
    total++; if (snap_h != HT) begin bad++; $display("[TB] FAIL ideal_last_h: got %0d want %0d", snap_h, HT); end
    total++; if (snap_v != VT) begin bad++; $display("[TB] FAIL ideal_last_v: got %0d want %0d", snap_v, VT); end
    // Sync lines wiggle while vga_clk is static: nothing may move.
    p1 = pulse_cnt;
    repeat (10) begin
      @(negedge Clk); hs_in = 1'b0; vs_in = 1'b0; blank_in = 1'b1;
      @(negedge Clk); hs_in = 1'b1; vs_in = 1'b1; blank_in = 1'b0;
    end
    repeat (3) @(negedge Clk);
    total++; if (pulse_cnt != p1) begin bad++; $display("[TB] FAIL static_pulses: got %0d want %0d", pulse_cnt, p1); end
    total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL static_locked: got %0b want 1", locked); end
  endtask

  task automatic test_active();
    do_reset();
    @(negedge Clk);
    hs_in = 1'b1; vs_in = 1'b1; blank_in = 1'b1; vga_clk_in = 1'b1;
    @(negedge Clk);
    total++; if (rx_de !== 1'b0) begin bad++; $display("[TB] FAIL latency_cycle1: got %0b want 0", rx_de); end
    vga_clk_in = 1'b0;
    @(negedge Clk);
    total++; if (rx_de !== 1'b1) begin bad++; $display("[TB] FAIL latency_cycle2: got %0b want 1", rx_de); end
    total++; if (rx_x !== 10'd0 || rx_y !== 10'd0) begin bad++; $display("[TB] FAIL latency_xy: got %0d/%0d want 0/0", rx_x, rx_y); end
    @(negedge Clk);
    total++; if (rx_de !== 1'b0) begin bad++; $display("[TB] FAIL de_one_cycle: got %0b want 0", rx_de); end
    blank_in = 1'b0;
    repeat (3) send_frame(0, VT, -1, 0, 1'b0);
    total++; if (snap_de != HA * VA) begin bad++; $display("[TB] FAIL active_count: got %0d want %0d", snap_de, HA * VA); end
    total++; if (snap_fx != 0 || snap_fy != 0) begin bad++; $display("[TB] FAIL first_pixel: got %0d/%0d want 0/0", snap_fx, snap_fy); end
    total++; if (snap_lx != HA - 1 || snap_ly != VA - 1) begin bad++; $display("[TB] FAIL last_pixel: got %0d/%0d want %0d/%0d", snap_lx, snap_ly, HA - 1, VA - 1); end
  endtask

  task automatic test_bad_line();
    do_reset();
    for (int f = 0; f < 7; f++) begin
      send_frame(0, VT, (f == 4) ? 3 : -1, HT - 1, 1'b0);
      if (f == 3) begin
        total++; if (snap_locked != 1) begin bad++; $display("[TB] FAIL badline_locked_before: got %0d want 1", snap_locked); end
      end
      if (f == 4) begin
        total++; if (snap_locked != 0) begin bad++; $display("[TB] FAIL badline_unlock: got %0d want 0", snap_locked); end
        total++; if (snap_err != 1) begin bad++; $display("[TB] FAIL badline_err: got %0d want 1", snap_err); end
        total++; if (snap_h != HT - 1) begin bad++; $display("[TB] FAIL badline_last_h: got %0d want %0d", snap_h, HT - 1); end
      end
      if (f == 5) begin
        total++; if (snap_locked != 0) begin bad++; $display("[TB] FAIL relock_early: got %0d want 0", snap_locked); end
      end
      if (f == 6) begin
        total++; if (snap_locked != 1) begin bad++; $display("[TB] FAIL relock: got %0d want 1", snap_locked); end
        total++; if (snap_err != 1) begin bad++; $display("[TB] FAIL relock_err: got %0d want 1", snap_err); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    send_frame(0, 2, -1, 0, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL midreset_locked: got %0b want 0", locked); end
    total++; if (err_count !== 8'd0) begin bad++; $display("[TB] FAIL midreset_err: got %0d want 0", err_count); end
    total++; if (last_h_period !== 10'd0) begin bad++; $display("[TB] FAIL midreset_last_h: got %0d want 0", last_h_period); end
    total++; if (last_v_lines !== 10'd0) begin bad++; $display("[TB] FAIL midreset_last_v: got %0d want 0", last_v_lines); end
    total++; if (rx_x !== 10'd0) begin bad++; $display("[TB] FAIL midreset_rx_x: got %0d want 0", rx_x); end
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    p0 = pulse_cnt;
    send_frame(2, VT, -1, 0, 1'b0);
    total++; if (pulse_cnt != p0) begin bad++; $display("[TB] FAIL midreset_unjudged: got %0d pulses want 0", pulse_cnt - p0); end
    send_frame(0, VT, -1, 0, 1'b0);
    total++; if (snap_locked != 0) begin bad++; $display("[TB] FAIL midreset_vs2: got locked %0d want 0", snap_locked); end
    send_frame(0, VT, -1, 0, 1'b0);
    total++; if (snap_locked != 1 || pulse_cnt - p0 != 2) begin bad++; $display("[TB] FAIL midreset_vs3: got locked %0d pulses %0d want 1 2", snap_locked, pulse_cnt - p0); end
  endtask

  task automatic test_short_frames();
    for (int i = 1; i <= 260; i++) begin
      send_frame(0, VT - 1, -1, 0, 1'b0);
      if (i == 2) begin
        total++; if (snap_err != 1 || snap_locked != 0) begin bad++; $display("[TB] FAIL short_first_bad: got err %0d locked %0d want 1 0", snap_err, snap_locked); end
      end
      if (i == 255) begin
        total++; if (snap_err != 254) begin bad++; $display("[TB] FAIL short_err254: got %0d want 254", snap_err); end
      end
      if (i == 256) begin
        total++; if (snap_err != 255) begin bad++; $display("[TB] FAIL short_err255: got %0d want 255", snap_err); end
      end
    end
    total++; if (err_count !== 8'd255) begin bad++; $display("[TB] FAIL short_err_sat: got %0d want 255", err_count); end
    total++; if (last_v_lines !== 10'(VT - 1)) begin bad++; $display("[TB] FAIL short_last_v: got %0d want %0d", last_v_lines, VT - 1); end
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL short_locked: got %0b want 0", locked); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    send_frame(0, VT, -1, 0, 1'b1);
    send_frame(0, VT, -1, 0, 1'b1);
    total++; if (snap_v != VT || snap_err != 0) begin bad++; $display("[TB] FAIL simul_frame1: got lines %0d err %0d want %0d 0", snap_v, snap_err, VT); end
    send_frame(0, VT, -1, 0, 1'b1);
    total++; if (snap_v != VT) begin bad++; $display("[TB] FAIL simul_last_v: got %0d want %0d", snap_v, VT); end
    total++; if (snap_locked != 1 || snap_err != 0) begin bad++; $display("[TB] FAIL simul_lock: got locked %0d err %0d want 1 0", snap_locked, snap_err); end
  endtask

  task automatic test_long_line();
    do_reset();
    send_frame(0, VT, -1, 0, 1'b0);
    send_frame(0, VT, -1, 0, 1'b0);
    send_frame(0, VT, 3, 1100, 1'b0);
    total++; if (snap_h != 1023) begin bad++; $display("[TB] FAIL long_last_h: got %0d want 1023", snap_h); end
    total++; if (snap_err != 1 || snap_locked != 0) begin bad++; $display("[TB] FAIL long_bad: got err %0d locked %0d want 1 0", snap_err, snap_locked); end
  endtask

  initial begin
    test_reset();
    test_ideal_lock();
    test_active();
    test_bad_line();
    test_reset_mid();
    test_short_frames();
    test_simultaneous();
    test_long_line();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
